ibus_spi_flash: RTL

//  Read-only Wishbone-style slave that serves 32-bit instruction fetches from SPI NOR flash.

---
 rtl/ibus_spi_flash.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ibus_spi_flash.sv
// Read-only iBus slave: serves each 32-bit fetch with a SPI NOR READ (0x03),
// a 24-bit address and 32 data bits, then pulses wb_ack for one cycle.
module ibus_spi_flash #(
    parameter int unsigned CLK_DIV      = 1,
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter int unsigned CS_GAP       = 2
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_cyc,
    input  logic [31:0] wb_adr,
    output logic        wb_ack,
    output logic [31:0] wb_rdt,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned      GAP_W    = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_GAP);
    localparam logic [7:0]       CMD_READ = 8'h03;

    typedef enum logic [1:0] {IDLE, SHIFT, ACK, GAP} state_t;

    state_t           state, state_nx;
    logic [63:0]      shreg, shreg_nx;
    logic [31:0]      rx, rx_nx;
    logic [6:0]       bit_cnt, bit_cnt_nx;
    logic [DIV_W-1:0] div_cnt, div_cnt_nx;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
    logic             ack_nx;
    logic [31:0]      rdt_nx;
    logic             cs_n_nx, sck_nx, mosi_nx;

    logic [23:0]      flash_adr;
    logic             tick, last_bit;
    logic             unused_adr;

    // 24-bit add: carry out of bit 23 is dropped so the image offset wraps.
    assign flash_adr  = {wb_adr[23:2], 2'b00} + FLASH_OFFSET;
    assign tick       = (div_cnt == DIV_LAST);
    assign last_bit   = (bit_cnt == 7'd63);
    assign unused_adr = ^{wb_adr[31:24], wb_adr[1:0]};

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state    <= GAP;
            gap_cnt  <= GAP_INIT;
            shreg    <= '0;
            rx       <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            wb_ack   <= 1'b0;
            wb_rdt   <= '0;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_cnt_nx;
            shreg    <= shreg_nx;
            rx       <= rx_nx;
            bit_cnt  <= bit_cnt_nx;
            div_cnt  <= div_cnt_nx;
            wb_ack   <= ack_nx;
            wb_rdt   <= rdt_nx;
            spi_cs_n <= cs_n_nx;
            spi_sck  <= sck_nx;
            spi_mosi <= mosi_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wb_cyc) state_nx = SHIFT;
            end
            SHIFT: begin
                if (!wb_cyc)                          state_nx = GAP;
                else if (tick && spi_sck && last_bit) state_nx = ACK;
            end
            ACK: begin
                state_nx = GAP;
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        shreg_nx   = shreg;
        rx_nx      = rx;
        bit_cnt_nx = bit_cnt;
        div_cnt_nx = div_cnt;
        gap_cnt_nx = gap_cnt;
        ack_nx     = 1'b0;
        rdt_nx     = '0;
        cs_n_nx    = 1'b1;
        sck_nx     = 1'b0;
        mosi_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (wb_cyc) begin
                    shreg_nx   = {CMD_READ, flash_adr, 32'h0};
                    bit_cnt_nx = '0;
                    div_cnt_nx = '0;
                    cs_n_nx    = 1'b0;
                    mosi_nx    = CMD_READ[7];
                end
            end
            SHIFT: begin
                if (!wb_cyc) begin
                    gap_cnt_nx = GAP_INIT;
                end else begin
                    cs_n_nx    = 1'b0;
                    sck_nx     = spi_sck;
                    mosi_nx    = spi_mosi;
                    div_cnt_nx = tick ? '0 : div_cnt + 1'b1;
                    if (tick && !spi_sck) begin
                        sck_nx = 1'b1;
                        // bit_cnt 32..63 is the data phase
                        if (bit_cnt[5]) rx_nx = {rx[30:0], spi_miso};
                    end else if (tick) begin
                        sck_nx = 1'b0;
                        if (last_bit) begin
                            cs_n_nx = 1'b1;
                            mosi_nx = 1'b0;
                        end else begin
                            bit_cnt_nx = bit_cnt + 7'd1;
                            shreg_nx   = {shreg[62:0], 1'b0};
                            // low 32 bits of shreg are zero, so mosi idles low in the data phase
                            mosi_nx    = shreg[62];
                        end
                    end
                end
            end
            ACK: begin
                ack_nx     = 1'b1;
                // first byte on the wire lands in [7:0]
                rdt_nx     = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                gap_cnt_nx = GAP_INIT;
            end
            GAP: begin
                gap_cnt_nx = gap_cnt - 1'b1;
            end
        endcase
    end

endmodule
